// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_seq_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    // Counter value on the edge that performs the 16th and final iteration.
    localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mult_state_t;

endpackage

// File: rtl/my_adder_16.sv
// Shared 16-bit combinational adder. Carry-out is dropped, so sums wrap modulo 2^16.
module my_adder_16 (
    output logic [15:0] out,
    input  logic [15:0] a,
    input  logic [15:0] b
);

    assign out = a + b;

endmodule

// File: rtl/mult_seq_16.sv
// Sequential 16-bit shift-and-add multiplier. It performs one partial-product add
// per clock through a single shared adder and returns the low 16 bits of a*b.
// Both the operand and the result sides use a valid/ready handshake.
module mult_seq_16
    import mult_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);

    mult_state_t       state;
    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  mplier_shifted;
    logic              run_last;

    // The adder sees acc/mcand continuously; its sum is only used in RUN when mplier[0] is set.
    my_adder_16 u_adder (
        .out (sum),
        .a   (acc),
        .b   (mcand)
    );

    assign mplier_shifted = mplier >> 1;

    // This RUN edge is the final iteration: the 16th one, or (early exit) no multiplier bits remain.
    assign run_last = (cnt == LAST_ITER) || (EARLY_EXIT && (mplier_shifted == '0));

    // Handshake and status flags decode straight from the state register, never from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = acc;

    // Control FSM plus the datapath shift registers, accumulator and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples the pre-edge values
            // (run_last and sum are computed from the old mplier/cnt/acc, as the algorithm needs).
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= (EARLY_EXIT && (b == '0)) ? DONE : RUN;
                    end
                end

                RUN: begin
                    if (mplier[0]) begin
                        acc <= sum;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier_shifted;
                    cnt    <= cnt + 5'd1;
                    if (run_last) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_16.sv
// Scoreboard bench for mult_seq_16. Two instances run side by side, one with
// EARLY_EXIT=0 and one with EARLY_EXIT=1. The drivers push the expected product
// and latency when an operand pair is accepted, and a monitor compares them
// when the result is presented.
module tb_mult_seq_16;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv0, iv1;
    logic [15:0] a0, a1, b0, b1;
    logic        ordy0, ordy1;
    logic        irdy0, irdy1;
    logic        ov0, ov1;
    logic        busy0, busy1;
    logic [15:0] p0, p1;

    bit          pv0 = 1'b0;
    bit          pv1 = 1'b0;

    mult_seq_16 #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_ready  (irdy0),
        .a         (a0),
        .b         (b0),
        .out_valid (ov0),
        .out_ready (ordy0),
        .product   (p0),
        .busy      (busy0)
    );

    mult_seq_16 #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_ready  (irdy1),
        .a         (a1),
        .b         (b1),
        .out_valid (ov1),
        .out_ready (ordy1),
        .product   (p1),
        .busy      (busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and hold it until accepted; the expectation is queued just before the accept edge.
    task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] prod, input int lat, input bit push, input string name);
        exp_t e;
        bit   done;
        done = 1'b0;
        if (sel == 0) begin a0 = a; b0 = b; iv0 = 1'b1; end
        else          begin a1 = a; b1 = b; iv1 = 1'b1; end
        for (int k = 0; k < 200 && !done; k++) begin
            if ((sel == 0) ? irdy0 : irdy1) begin
                e.prod    = prod;
                e.lat     = lat;
                e.acc_cyc = cyc;
                e.name    = name;
                if (push) begin
                    if (sel == 0) q0.push_back(e);
                    else          q1.push_back(e);
                end
                done = 1'b1;
            end
            step();
        end
        if (sel == 0) iv0 = 1'b0;
        else          iv1 = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s: operand pair never accepted", name);
        end
    endtask

    // One monitor step for one instance: latency when out_valid rises, product on output transfer.
    task automatic mon(input int sel, input logic ov, input logic ordy, input logic [15:0] p);
        exp_t e;
        bit   empty;
        bit   pv;
        empty = (sel == 0) ? (q0.size() == 0) : (q1.size() == 0);
        pv    = (sel == 0) ? pv0 : pv1;
        if (ov) begin
            if (empty) begin
                tests++;
                fails++;
                $display("FAIL dut%0d unexpected out_valid: product 0x%0h with no pending operation", sel, p);
            end else begin
                if (sel == 0) e = q0[0];
                else          e = q1[0];
                if (!pv) check({e.name, " latency"}, cyc - e.acc_cyc, e.lat);
                if (ordy) begin
                    check({e.name, " product"}, {16'h0, p}, {16'h0, e.prod});
                    if (sel == 0) void'(q0.pop_front());
                    else          void'(q1.pop_front());
                end
            end
        end
        if (sel == 0) pv0 = ov;
        else          pv1 = ov;
    endtask

    always @(negedge clk) begin
        mon(0, ov0, ordy0, p0);
        mon(1, ov1, ordy1, p1);
    end

    task automatic wait_drain(input string name);
        for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0); k++) step();
        if (q0.size() != 0 || q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: %0d/%0d results still pending, expected 0", name, q0.size(), q1.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv0 = 1'b0; iv1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        ordy0 = 1'b1; ordy1 = 1'b1;

        // Reset state, sampled before any clock edge.
        #2;
        check("reset in_ready",  irdy1, 1);
        check("reset out_valid", ov1,   0);
        check("reset busy",      busy1, 0);
        check("reset product",   p1,    0);
        check("reset in_ready0", irdy0, 1);
        check("reset busy0",     busy0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // EARLY_EXIT=0: always 16 iterations, latency 17.
        do_op(0, 16'hFFFF, 16'hFFFF, 16'h0001, 17, 1'b1, "ee0 ffff*ffff");
        for (int k = 0; k < 16; k++) begin
            check("ee0 busy during run", busy0, 1);
            step();
        end
        do_op(0, 16'd3, 16'd5, 16'd15, 17, 1'b1, "ee0 3*5");
        do_op(0, 16'h1234, 16'h0000, 16'h0000, 17, 1'b1, "ee0 b=0");
        wait_drain("ee0 drain");

        // EARLY_EXIT=1: latency is index of highest set bit of b plus 2.
        do_op(1, 16'd3, 16'd5, 16'd15, 4, 1'b1, "ee1 3*5");
        do_op(1, 16'h8000, 16'd2, 16'h0000, 3, 1'b1, "ee1 wrap 8000*2");
        do_op(1, 16'h4000, 16'd2, 16'h8000, 3, 1'b1, "ee1 4000*2");
        do_op(1, 16'h1234, 16'd0, 16'h0000, 1, 1'b1, "ee1 b=0");
        do_op(1, 16'h0003, 16'h8001, 16'h8003, 17, 1'b1, "ee1 b msb set");
        do_op(1, 16'h00FF, 16'h0101, 16'hFFFF, 10, 1'b1, "ee1 ff*101");
        wait_drain("ee1 drain");

        // Backpressure: DONE holds the product and refuses new operands.
        ordy1 = 1'b0;
        do_op(1, 16'd7, 16'd6, 16'd42, 4, 1'b1, "bp 7*6");
        for (int k = 0; k < 50 && !ov1; k++) step();
        check("bp out_valid reached", ov1, 1);
        a1 = 16'd9; b1 = 16'd3; iv1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp product held", p1,    42);
            check("bp in_ready low", irdy1, 0);
            check("bp out_valid",    ov1,   1);
        end
        ordy1 = 1'b1;
        step();
        check("bp idle after transfer", irdy1, 1);
        do_op(1, 16'd9, 16'd3, 16'd27, 3, 1'b1, "bp next 9*3");
        wait_drain("bp drain");

        // Asynchronous reset in the middle of RUN discards the operation.
        do_op(1, 16'h00FF, 16'h0F0F, 16'h0000, 0, 1'b0, "rst op");
        step();
        step();
        check("pre-reset busy", busy1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset busy",      busy1, 0);
        check("async reset out_valid", ov1,   0);
        check("async reset in_ready",  irdy1, 1);
        check("async reset product",   p1,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        do_op(1, 16'd7, 16'd6, 16'd42, 4, 1'b1, "post-reset 7*6");
        wait_drain("final drain");
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_seq_16.md
# mult_seq_16

Sequential 16-bit shift-and-add multiplier that drives one instance of the shared `my_adder_16` combinational adder for one partial-product add per clock. It accepts operand pairs over a valid/ready handshake and returns the low 16 bits of the product over a second valid/ready handshake. It is the first controller layered on the adder datapath and the template for later multi-cycle ALU sequencers.

## Interface
- `EARLY_EXIT`, default 1: 1 means finish as soon as the remaining multiplier bits are all zero; 0 means always run 16 iterations.
- `clk  input  1`: single clock; all state changes on the rising edge.
- `rst_n  input  1`: reset, asynchronous and active-low.
- `in_valid  input  1`: operand pair on `a`/`b` is valid.
- `in_ready  output  1`: block can accept an operand pair; high only in IDLE.
- `a  input  16`: multiplicand.
- `b  input  16`: multiplier.
- `out_valid  output  1`: `product` is valid; high only in DONE.
- `out_ready  input  1`: consumer accepts `product`.
- `product  output  16`: (a*b) mod 2^16.
- `busy  output  1`: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - `mcand` (16 bits)
  - `mplier` (16 bits)
  - `acc` (16 bits)
  - `cnt` (5 bits)
- IDLE:
  - An input transfer is `in_valid && in_ready` on a rising edge with `rst_n` high.
  - On transfer: load `mcand=a`, `mplier=b`, `acc=0`, `cnt=0`.
  - Next state is DONE if `EARLY_EXIT=1` and `b==0`; otherwise RUN.
- RUN, one iteration per edge:
  - If `mplier[0]`, set `acc` to the `my_adder_16` sum of (`acc`, `mcand`); otherwise `acc` holds.
  - Then `mcand <<= 1` (bit 15 discarded), `mplier >>= 1`, `cnt++`.
  - Exit to DONE when `cnt` reaches 15 on this edge (16th iteration).
  - With `EARLY_EXIT=1`, also exit to DONE when the shifted `mplier` is 0.
- DONE:
  - `product=acc`, held stable.
  - Output transfer is `out_valid && out_ready` on a rising edge; next state IDLE.
  - `in_valid` is ignored; no new operands are accepted.
- Arithmetic:
  - All adds are modulo 2^16; overflow is neither detected nor flagged, matching the adder.
  - Only the low 16 bits of the true product are produced.
- Adder inputs are driven continuously from `acc`/`mcand`; the adder output is used only in RUN when `mplier[0]=1`.
- Reset, including mid-RUN or mid-DONE:
  - All registers clear immediately; state goes to IDLE.
  - The in-flight operation is discarded with no partial output.
- Output reset values:
  - `out_valid=0`, `busy=0`, `product=0`.
  - `in_ready=1` once in IDLE.
- Inputs `a`/`b` may change freely after the accept edge; they are captured.

## Timing
- R = RUN iterations:
  - `EARLY_EXIT=0`: R=16.
  - `EARLY_EXIT=1`: R = index of the highest set bit of `b` plus 1; R=0 for `b==0`.
- `out_valid` rises after the accept edge plus R further edges.
  - Latency accept→`out_valid` is R+1 edges (`b==0`: 1 edge).
- `in_ready` is low from the accept edge until the edge after the output transfer; one bubble cycle in IDLE between back-to-back ops.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register (no combinational path from `in_valid`/`out_ready`).
- Throughput at `EARLY_EXIT=0` with `out_ready` held high: one product per 18 cycles.

## Structure
- Package `mult_seq_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t`
  - `localparam WIDTH=16`
  - `localparam CNT_W=5`
- Sub-module: exactly one instance of the existing `my_adder_16`, port order (out, a, b). No new sub-module.
- Control FSM, shift registers and counter all live in `mult_seq_16`.

## Test plan
- `a=3`, `b=5`, `EARLY_EXIT=1`, `out_ready=1` → `product=15`; `out_valid` exactly 4 edges after accept (R=3).
- `a=0xFFFF`, `b=0xFFFF`, `EARLY_EXIT=0` → `product=0x0001`; `out_valid` after 17 edges; `busy` high throughout.
- `a=0x8000`, `b=2` → `product=0x0000` (wrap), no error indication; `a=0x4000`, `b=2` → `0x8000`.
- `b=0`, `a=0x1234`, `EARLY_EXIT=1` → `product=0`, `out_valid` 1 edge after accept.
- `a=7`, `b=6`, `out_ready` held low 5 cycles with `in_valid=1` and new operands → `product` stays 42, `in_ready=0`, new operands not accepted; raise `out_ready` → IDLE next edge, then the new pair is accepted.
- Assert `rst_n=0` mid-RUN on `a=0x00FF`, `b=0x0F0F` → `busy`/`out_valid` drop to 0 immediately with no clock edge; after release, `a=7`, `b=6` → 42.
